// File: rtl/phase_scan_controller_pkg.sv
// Shared types and constants for the phase shifter scan controller.
// Holds the FSM state encoding and the step normalisation helper.
package phase_scan_controller_pkg;

    localparam int PHASE_W   = 5;
    localparam int PHASE_MOD = 32;
    // One extra bit so offset + step never wraps before it is compared with the span.
    localparam int OFFSET_W  = $clog2(PHASE_MOD) + 1;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_FINISH = 3'd5
    } scan_state_e;

    function automatic phase_t norm_step(input logic [2:0] step);
        return (step == 3'd0) ? phase_t'(1) : phase_t'(step);
    endfunction

endpackage

// File: rtl/phase_scan_controller_if.sv
// Control/status bundle between software-facing registers, the hit source
// and the phase scan controller.
interface phase_scan_controller_if
    import phase_scan_controller_pkg::*;
#(
    parameter int DWELL_W  = 8,
    parameter int SETTLE_W = 4
);

    logic                modeScan;
    logic                startScan;
    phase_t              manualDelay;
    phase_t              manualWidth;
    phase_t              scanStart;
    phase_t              scanStop;
    logic [2:0]          scanStep;
    logic [SETTLE_W-1:0] settleCycles;
    logic [DWELL_W-1:0]  dwellCycles;
    logic                hitIn;

    phase_t              clockDelay;
    phase_t              pulseWidth;
    logic                busy;
    logic                done;
    phase_t              bestDelay;
    logic [DWELL_W-1:0]  bestCount;

    modport master (
        output modeScan, startScan, manualDelay, manualWidth, scanStart,
               scanStop, scanStep, settleCycles, dwellCycles, hitIn,
        input  clockDelay, pulseWidth, busy, done, bestDelay, bestCount
    );

    modport slave (
        input  modeScan, startScan, manualDelay, manualWidth, scanStart,
               scanStop, scanStep, settleCycles, dwellCycles, hitIn,
        output clockDelay, pulseWidth, busy, done, bestDelay, bestCount
    );

endinterface

// File: rtl/phase_hit_counter.sv
// Saturating hit counter: synchronous clear has priority over enable,
// and the count sticks at all-ones instead of wrapping.
module phase_hit_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phase_scan_controller.sv
// Drives one phase shifter channel: forwards manual settings, or sweeps
// clockDelay over a window, counts hits per point and applies the best one.
module phase_scan_controller
    import phase_scan_controller_pkg::*;
#(
    parameter int DWELL_W  = 8,
    parameter int SETTLE_W = 4
) (
    input logic                    clk40,
    input logic                    reset,
    phase_scan_controller_if.slave bus
);

    scan_state_e         state_q, state_d;
    logic                start_prev_q, start_prev_d;
    logic                armed_q, armed_d;
    phase_t              cur_q, cur_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    phase_t              span_q, span_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    phase_t              clock_delay_q, clock_delay_d;
    phase_t              pulse_width_q, pulse_width_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    phase_t              best_delay_q, best_delay_d;
    logic [DWELL_W-1:0]  best_count_q, best_count_d;

    logic                hit_clr;
    logic                hit_en;
    logic [DWELL_W-1:0]  hit_count;
    logic                start_rise;
    phase_t              step;
    logic [OFFSET_W-1:0] offset_next;
    logic [DWELL_W-1:0]  dwell_load;

    phase_hit_counter #(
        .WIDTH (DWELL_W)
    ) u_hit_counter (
        .clk40 (clk40),
        .reset (reset),
        .clr   (hit_clr),
        .en    (hit_en),
        .count (hit_count)
    );

    // armed_q blocks a startScan level that was already high across reset
    // from looking like a fresh rising edge.
    assign start_rise  = bus.startScan && !start_prev_q && armed_q;
    assign step        = norm_step(bus.scanStep);
    assign offset_next = offset_q + OFFSET_W'(step);
    assign dwell_load  = (bus.dwellCycles == '0) ? DWELL_W'(1) : bus.dwellCycles;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        start_prev_d  = bus.startScan;
        armed_d       = armed_q || !bus.startScan;
        cur_d         = cur_q;
        offset_d      = offset_q;
        span_d        = span_q;
        settle_cnt_d  = settle_cnt_q;
        dwell_cnt_d   = dwell_cnt_q;
        clock_delay_d = clock_delay_q;
        pulse_width_d = pulse_width_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_delay_d  = best_delay_q;
        best_count_d  = best_count_q;
        hit_clr       = 1'b0;
        hit_en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.modeScan) begin
                    clock_delay_d = bus.manualDelay;
                    pulse_width_d = bus.manualWidth;
                end else if (start_rise) begin
                    state_d      = ST_APPLY;
                    cur_d        = bus.scanStart;
                    offset_d     = '0;
                    span_d       = bus.scanStop - bus.scanStart;
                    best_count_d = '0;
                    best_delay_d = bus.scanStart;
                    busy_d       = 1'b1;
                end
            end

            ST_APPLY: begin
                clock_delay_d = cur_q;
                pulse_width_d = bus.manualWidth;
                settle_cnt_d  = bus.settleCycles;
                dwell_cnt_d   = dwell_load;
                hit_clr       = 1'b1;
                state_d       = (bus.settleCycles == '0) ? ST_DWELL : ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_cnt_q <= SETTLE_W'(1)) begin
                    state_d = ST_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end

            ST_DWELL: begin
                hit_en = bus.hitIn;
                if (dwell_cnt_q <= DWELL_W'(1)) begin
                    state_d = ST_EVAL;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end

            ST_EVAL: begin
                // Strict compare: on a tie the earlier point stays best.
                if (hit_count > best_count_q) begin
                    best_count_d = hit_count;
                    best_delay_d = cur_q;
                end
                if (offset_next > OFFSET_W'(span_q)) begin
                    state_d       = ST_FINISH;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    clock_delay_d = best_delay_d;
                    pulse_width_d = bus.manualWidth;
                end else begin
                    state_d  = ST_APPLY;
                    offset_d = offset_next;
                    cur_d    = cur_q + step;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Dropping modeScan abandons the scan from any active state.
        if ((state_q != ST_IDLE) && !bus.modeScan) begin
            state_d       = ST_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            clock_delay_d = bus.manualDelay;
            pulse_width_d = bus.manualWidth;
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        // NOTE: non-blocking assignments only here, so every flop samples
        // the pre-edge value of every other flop regardless of order.
        if (reset) begin
            state_q       <= ST_IDLE;
            start_prev_q  <= 1'b0;
            armed_q       <= 1'b0;
            cur_q         <= '0;
            offset_q      <= '0;
            span_q        <= '0;
            settle_cnt_q  <= '0;
            dwell_cnt_q   <= '0;
            clock_delay_q <= '0;
            pulse_width_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_delay_q  <= '0;
            best_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start_prev_d;
            armed_q       <= armed_d;
            cur_q         <= cur_d;
            offset_q      <= offset_d;
            span_q        <= span_d;
            settle_cnt_q  <= settle_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            clock_delay_q <= clock_delay_d;
            pulse_width_q <= pulse_width_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_delay_q  <= best_delay_d;
            best_count_q  <= best_count_d;
        end
    end

    assign bus.clockDelay = clock_delay_q;
    assign bus.pulseWidth = pulse_width_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bestDelay  = best_delay_q;
    assign bus.bestCount  = best_count_q;

endmodule

// File: tb/tb_phase_scan_controller.sv
// Directed bench for phase_scan_controller: manual forwarding, full/wrapped/
// single-point scans, abort, async reset, and hit saturation.
module tb_phase_scan_controller;

    logic clk40 = 1'b0;
    logic reset = 1'b1;
    logic hit_all = 1'b0;
    logic hc_clr = 1'b0;
    logic hc_en  = 1'b0;
    logic [3:0] hc_count;

    int n_checks = 0;
    int n_errors = 0;
    int pts[$];
    int cycles;
    int bad;

    always #5 clk40 = ~clk40;

    phase_scan_controller_if #(.DWELL_W(8), .SETTLE_W(4)) bus1 ();
    phase_scan_controller_if #(.DWELL_W(4), .SETTLE_W(4)) bus2 ();

    phase_scan_controller #(.DWELL_W(8), .SETTLE_W(4)) u_dut (
        .clk40 (clk40),
        .reset (reset),
        .bus   (bus1)
    );

    phase_scan_controller #(.DWELL_W(4), .SETTLE_W(4)) u_dut_sat (
        .clk40 (clk40),
        .reset (reset),
        .bus   (bus2)
    );

    phase_hit_counter #(.WIDTH(4)) u_hc (
        .clk40 (clk40),
        .reset (reset),
        .clr   (hc_clr),
        .en    (hc_en),
        .count (hc_count)
    );

    // Hit source for the main DUT: responds only at delay 12 unless forced.
    always_comb bus1.hitIn = hit_all | (bus1.clockDelay == 5'd12);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg1(input int start, input int stop, input int stp, input int settle, input int dwell);
        bus1.scanStart    = 5'(start);
        bus1.scanStop     = 5'(stop);
        bus1.scanStep     = 3'(stp);
        bus1.settleCycles = 4'(settle);
        bus1.dwellCycles  = 8'(dwell);
    endtask

    // Starts a scan on the main DUT and records each applied delay until done.
    task automatic run_scan1(input int budget, output int n_cyc);
        pts.delete();
        n_cyc = -1;
        @(negedge clk40) bus1.startScan = 1'b1;
        @(posedge clk40);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk40);
            #1;
            if (c == 1) pts.push_back(int'(bus1.clockDelay));
            else if (bus1.busy && (int'(bus1.clockDelay) != pts[$])) pts.push_back(int'(bus1.clockDelay));
            if (bus1.done) begin
                n_cyc = c;
                break;
            end
        end
        @(negedge clk40) bus1.startScan = 1'b0;
    endtask

    initial begin
        int saw;
        bus1.modeScan = 1'b0; bus1.startScan = 1'b0;
        bus1.manualDelay = 5'd0; bus1.manualWidth = 5'd0;
        cfg1(0, 0, 0, 0, 0);
        bus2.modeScan = 1'b0; bus2.startScan = 1'b0; bus2.hitIn = 1'b1;
        bus2.manualDelay = 5'd0; bus2.manualWidth = 5'd0;
        bus2.scanStart = 5'd3; bus2.scanStop = 5'd6; bus2.scanStep = 3'd1;
        bus2.settleCycles = 4'd1; bus2.dwellCycles = 4'd15;

        #1;
        check("rst_clockDelay", bus1.clockDelay, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_bestCount", bus1.bestCount, 0);
        repeat (2) @(negedge clk40);
        reset = 1'b0;

        // Manual forwarding, both words on the same edge.
        @(negedge clk40) begin bus1.manualDelay = 5'd7; bus1.manualWidth = 5'd16; end
        @(posedge clk40) #1;
        check("man_delay_7", bus1.clockDelay, 7);
        check("man_width_16", bus1.pulseWidth, 16);
        @(negedge clk40) begin bus1.manualDelay = 5'd9; bus1.manualWidth = 5'd20; end
        #1 check("man_hold_before_edge", bus1.clockDelay, 7);
        @(posedge clk40) #1;
        check("man_delay_9", bus1.clockDelay, 9);
        check("man_width_20", bus1.pulseWidth, 20);

        // Full 32-point scan, hit only at delay 12.
        @(negedge clk40) begin bus1.modeScan = 1'b1; cfg1(0, 31, 1, 2, 10); end
        run_scan1(600, cycles);
        check("full_cycles", cycles, 448);
        check("full_points", pts.size(), 32);
        bad = 0;
        foreach (pts[i]) if (pts[i] != i) bad++;
        check("full_order", bad, 0);
        check("full_bestDelay", bus1.bestDelay, 12);
        check("full_bestCount", bus1.bestCount, 10);
        check("full_applied", bus1.clockDelay, 12);
        check("full_busy", bus1.busy, 0);
        check("full_width", bus1.pulseWidth, 20);
        repeat (3) @(posedge clk40);
        #1;
        check("full_done_pulse", bus1.done, 0);
        check("latch_best_applied", bus1.clockDelay, 12);

        // Wrapped window 28..3 step 2: 28, 30, 0, 2.
        @(negedge clk40) cfg1(28, 3, 2, 0, 1);
        run_scan1(100, cycles);
        check("wrap_cycles", cycles, 12);
        check("wrap_points", pts.size(), 4);
        if (pts.size() == 4) begin
            check("wrap_p0", pts[0], 28);
            check("wrap_p1", pts[1], 30);
            check("wrap_p2", pts[2], 0);
            check("wrap_p3", pts[3], 2);
        end
        check("wrap_bestDelay", bus1.bestDelay, 28);
        check("wrap_applied", bus1.clockDelay, 28);

        // Single point, step 0 and dwell 0 both behave as 1.
        @(negedge clk40) cfg1(9, 9, 0, 0, 0);
        run_scan1(50, cycles);
        check("single_cycles", cycles, 3);
        check("single_points", pts.size(), 1);
        check("single_applied", bus1.clockDelay, 9);

        // Abort during DWELL of point 5.
        @(negedge clk40) cfg1(0, 31, 1, 2, 10);
        @(negedge clk40) bus1.startScan = 1'b1;
        @(posedge clk40);
        repeat (75) @(posedge clk40);
        #1;
        check("abort_pre_delay", bus1.clockDelay, 5);
        check("abort_pre_busy", bus1.busy, 1);
        @(negedge clk40) begin bus1.modeScan = 1'b0; bus1.manualDelay = 5'd3; end
        @(posedge clk40) #1;
        check("abort_busy", bus1.busy, 0);
        check("abort_manual", bus1.clockDelay, 3);
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk40) #1;
            if (bus1.done || bus1.busy) saw++;
        end
        check("abort_no_done", saw, 0);
        check("abort_partial_best", bus1.bestDelay, 0);
        @(negedge clk40) bus1.startScan = 1'b0;

        // Async reset in SETTLE with startScan held high.
        @(negedge clk40) begin bus1.modeScan = 1'b1; cfg1(4, 31, 1, 5, 10); end
        @(negedge clk40) bus1.startScan = 1'b1;
        @(posedge clk40);
        @(posedge clk40);
        #1 check("rstmid_pre_busy", bus1.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_clockDelay", bus1.clockDelay, 0);
        check("rstmid_pulseWidth", bus1.pulseWidth, 0);
        check("rstmid_bestDelay", bus1.bestDelay, 0);
        check("rstmid_busy", bus1.busy, 0);
        repeat (2) @(negedge clk40);
        reset = 1'b0;
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk40) #1;
            if (bus1.busy) saw++;
        end
        check("rstmid_no_restart", saw, 0);
        @(negedge clk40) bus1.startScan = 1'b0;
        @(negedge clk40) bus1.startScan = 1'b1;
        @(posedge clk40) #1;
        check("rstmid_retrigger", bus1.busy, 1);
        @(negedge clk40) begin bus1.modeScan = 1'b0; bus1.startScan = 1'b0; end

        // Tie across all points on the 4-bit instance.
        @(negedge clk40) bus2.modeScan = 1'b1;
        @(negedge clk40) bus2.startScan = 1'b1;
        @(posedge clk40);
        cycles = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk40) #1;
            if (bus2.done) begin
                cycles = c;
                break;
            end
        end
        check("tie_cycles", cycles, 72);
        check("tie_bestCount", bus2.bestCount, 15);
        check("tie_bestDelay", bus2.bestDelay, 3);
        check("tie_applied", bus2.clockDelay, 3);

        // Hit counter saturates rather than wrapping.
        @(negedge clk40) hc_clr = 1'b1;
        @(negedge clk40) begin hc_clr = 1'b0; hc_en = 1'b1; end
        repeat (20) @(negedge clk40);
        hc_en = 1'b0;
        check("hc_saturate", hc_count, 15);
        hc_clr = 1'b1;
        @(negedge clk40) hc_clr = 1'b0;
        check("hc_clear", hc_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
